// File: rtl/fifo_enq_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared constants and types for the FIFO enqueue arbiter slice.
//   N_REQ  : number of producers sharing the FIFO write port
//   W_REQ  : width of a requester index
//   WIDTH  : data width, equal to the FIFO data width
//   DEPTH  : FIFO depth, which is also the initial credit count
//   W_CNT  : credit counter width, holds 0..DEPTH
// Optional feature macro used by the slice: ARB_LOCK_EN (owner lock).
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int N_REQ = 4;
  localparam int W_REQ = 2;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int W_CNT = 3;

  typedef logic [W_REQ-1:0] req_idx_t;
  typedef logic [W_CNT-1:0] credit_t;

  // Lock FSM states; only used when ARB_LOCK_EN is defined.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lockState_e;

  // Next requester index after i, wrapping at N_REQ-1.
  function automatic req_idx_t nextIdx(input req_idx_t i);
    if (int'(i) == N_REQ - 1) begin
      return '0;
    end
    return req_idx_t'(int'(i) + 1);
  endfunction

endpackage

// File: rtl/fifo_enq_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_enq_arbiter_if
// Bundles the producer handshake, the FIFO write side and the dequeue
// credit return of the enqueue arbiter.
//   REQ      : per-requester enqueue request (level)
//   DIN      : requester data, slice i = DIN[i*WIDTH +: WIDTH]
//   GNT      : one-hot combinational grant
//   ENQ_O    : registered enqueue strobe to the FIFO
//   DOUT     : registered data to the FIFO
//   DEQ_DONE : FIFO entry consumed this cycle
//   CREDIT   : current free-slot count
//   ERR      : sticky protocol-error flag
//   LOCK     : owner lock request (only with ARB_LOCK_EN)
// Modports: master = producers/consumer side, slave = arbiter.
// ---------------------------------------------------------------------------
interface fifo_enq_arbiter_if;
  import fifo_arb_pkg::*;

  logic [N_REQ-1:0]       REQ;
  logic [N_REQ*WIDTH-1:0] DIN;
  logic [N_REQ-1:0]       GNT;
  logic                   ENQ_O;
  logic [WIDTH-1:0]       DOUT;
  logic                   DEQ_DONE;
  credit_t                CREDIT;
  logic                   ERR;
`ifdef ARB_LOCK_EN
  logic                   LOCK;

  modport master (
    output REQ, DIN, DEQ_DONE, LOCK,
    input  GNT, ENQ_O, DOUT, CREDIT, ERR
  );

  modport slave (
    input  REQ, DIN, DEQ_DONE, LOCK,
    output GNT, ENQ_O, DOUT, CREDIT, ERR
  );
`else
  modport master (
    output REQ, DIN, DEQ_DONE,
    input  GNT, ENQ_O, DOUT, CREDIT, ERR
  );

  modport slave (
    input  REQ, DIN, DEQ_DONE,
    output GNT, ENQ_O, DOUT, CREDIT, ERR
  );
`endif

endinterface

// File: rtl/fifo_enq_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches i_req starting at i_ptr and
// wrapping modulo N_REQ; the first set bit wins.
//   i_req    : request vector (may be pre-masked by the caller)
//   i_ptr    : search start index
//   i_en     : picker enable; no grant when low
//   o_gnt    : one-hot grant
//   o_winner : index of the granted requester
//   o_valid  : a grant was issued
// ---------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  req_idx_t         i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output req_idx_t         o_winner,
  output logic             o_valid
);

  // Walk the requesters in rotated order and keep only the first hit.
  always_comb begin
    int idx;
    idx      = 0;
    o_gnt    = '0;
    o_winner = '0;
    o_valid  = 1'b0;
    if (i_en) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(i_ptr) + k) % N_REQ;
        if (!o_valid && i_req[idx]) begin
          o_valid    = 1'b1;
          o_winner   = req_idx_t'(idx);
          o_gnt[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_enq_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_enq_arbiter
// Shares one FIFO write port among N_REQ producers with round-robin
// arbitration. A private credit counter tracks free FIFO slots so the
// arbiter never relies on the FIFO's lagging FULL flag.
//   clk : clock
//   rst : asynchronous active-high reset (release is synchronous)
//   bus : fifo_enq_arbiter_if.slave (REQ/DIN/GNT/ENQ_O/DOUT/DEQ_DONE/
//         CREDIT/ERR, plus LOCK when ARB_LOCK_EN is defined)
// Optional feature macro: ARB_LOCK_EN adds an owner-lock FSM.
// ---------------------------------------------------------------------------
module fifo_enq_arbiter
  import fifo_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fifo_enq_arbiter_if.slave   bus
);

  req_idx_t         r_rrPtr;
  credit_t          r_credit;
  logic             r_err;
  logic             r_enq;
  logic [WIDTH-1:0] r_dout;

  logic [N_REQ-1:0] w_pickReq;
  req_idx_t         w_pickPtr;
  logic             w_en;
  logic [N_REQ-1:0] w_gnt;
  req_idx_t         w_winner;
  logic             w_valid;
  logic             w_ptrLoad;
  req_idx_t         w_ptrNext;

  // No grant while in reset or when the FIFO has no free slot. A credit
  // returned this cycle only becomes usable on the next cycle.
  assign w_en = !rst && (r_credit != '0);

  rr_pick u_pick (
    .i_req    (w_pickReq),
    .i_ptr    (w_pickPtr),
    .i_en     (w_en),
    .o_gnt    (w_gnt),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

`ifdef ARB_LOCK_EN
  lockState_e       r_state;
  lockState_e       w_nextState;
  req_idx_t         r_owner;
  req_idx_t         w_ownerNext;
  logic [N_REQ-1:0] w_ownerMask;

  assign w_ownerMask = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;

  // While locked, only the owner's request reaches the picker.
  always_comb begin
    w_pickReq = bus.REQ;
    w_pickPtr = r_rrPtr;
    if (r_state == LOCKED) begin
      w_pickReq = bus.REQ & w_ownerMask;
      w_pickPtr = r_owner;
    end
  end

  // Lock FSM state register and owner latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_nextState;
      r_owner <= w_ownerNext;
    end
  end

  // Next state and pointer update. The pointer stays frozen for as long
  // as the lock is held and advances past the owner when it is released.
  always_comb begin
    w_nextState = r_state;
    w_ownerNext = r_owner;
    w_ptrLoad   = 1'b0;
    w_ptrNext   = r_rrPtr;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          if (bus.LOCK) begin
            w_nextState = LOCKED;
            w_ownerNext = w_winner;
          end else begin
            w_ptrLoad = 1'b1;
            w_ptrNext = nextIdx(w_winner);
          end
        end
      end
      LOCKED: begin
        if (!bus.REQ[r_owner] || (w_valid && !bus.LOCK)) begin
          w_nextState = IDLE;
          w_ptrLoad   = 1'b1;
          w_ptrNext   = nextIdx(r_owner);
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end
`else
  assign w_pickReq = bus.REQ;
  assign w_pickPtr = r_rrPtr;
  assign w_ptrLoad = w_valid;
  assign w_ptrNext = nextIdx(w_winner);
`endif

  // Round-robin pointer: moves just past the last winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rrPtr <= '0;
    end else if (w_ptrLoad) begin
      r_rrPtr <= w_ptrNext;
    end
  end

  // Credit counter and sticky error. A dequeue arriving when every slot
  // is already free is a consumer protocol violation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= credit_t'(DEPTH);
      r_err    <= 1'b0;
    end else begin
      case ({w_valid, bus.DEQ_DONE})
        2'b10: r_credit <= r_credit - 1'b1;
        2'b01: begin
          if (r_credit == credit_t'(DEPTH)) begin
            r_err <= 1'b1;
          end else begin
            r_credit <= r_credit + 1'b1;
          end
        end
        default: r_credit <= r_credit;
      endcase
    end
  end

  // Registered write port; data is zero on idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enq  <= 1'b0;
      r_dout <= '0;
    end else begin
      r_enq  <= w_valid;
      r_dout <= w_valid ? bus.DIN[w_winner*WIDTH +: WIDTH] : '0;
    end
  end

  assign bus.GNT    = w_gnt;
  assign bus.ENQ_O  = r_enq;
  assign bus.DOUT   = r_dout;
  assign bus.CREDIT = r_credit;
  assign bus.ERR    = r_err;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_enq_arbiter
// Directed, table-driven bench for fifo_enq_arbiter. Each table row gives
// the inputs for one cycle, the combinational GNT/CREDIT expected before
// the edge and the registered ENQ_O/DOUT/ERR expected after it.
// Lock scenarios are included when ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_fifo_enq_arbiter;
  import fifo_arb_pkg::*;

  typedef struct {
    logic [3:0]  req;
    logic        deq;
    logic [3:0]  gnt;
    logic [2:0]  credit;
    logic        enq;
    logic [31:0] dout;
    logic        err;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fifo_enq_arbiter_if bus ();

  fifo_enq_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle's inputs just after an edge and lets them settle
  // to mid-cycle, where combinational outputs are sampled.
  task automatic applyStimulus(input logic [3:0] req, input logic deq,
                               input logic lock);
    bus.REQ      = req;
    bus.DEQ_DONE = deq;
`ifdef ARB_LOCK_EN
    bus.LOCK     = lock;
`else
    if (lock) begin
      $display("[TB] lock stimulus ignored in this build");
    end
`endif
    #4;
  endtask

  // Advances to 1 ns after the next rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic setDefaultData();
    for (int i = 0; i < N_REQ; i++) begin
      bus.DIN[i*WIDTH +: WIDTH] = 32'(100 + i);
    end
  endtask

  task automatic doReset();
    bus.REQ      = '0;
    bus.DEQ_DONE = 1'b0;
`ifdef ARB_LOCK_EN
    bus.LOCK     = 1'b0;
`endif
    rst = 1'b1;
    stepClock();
    @(negedge clk);
    rst = 1'b0;
    stepClock();
  endtask

  vec_t vecs[23];

  initial begin
    checks = 0;
    errors = 0;

    // Cycle table: fill from a known post-reset state (ptr 0, credit 5).
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 3'd5, 1'b1, 32'd100, 1'b0};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 3'd4, 1'b1, 32'd101, 1'b0};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 3'd3, 1'b1, 32'd102, 1'b0};
    vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 3'd2, 1'b1, 32'd103, 1'b0};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 3'd1, 1'b1, 32'd100, 1'b0};
    vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 3'd0, 1'b0, 32'd0,   1'b0};
    // Empty credit: dequeue does not allow a same-cycle grant.
    vecs[6]  = '{4'b0010, 1'b1, 4'b0000, 3'd0, 1'b0, 32'd0,   1'b0};
    vecs[7]  = '{4'b0010, 1'b0, 4'b0010, 3'd1, 1'b1, 32'd101, 1'b0};
    vecs[8]  = '{4'b0010, 1'b0, 4'b0000, 3'd0, 1'b0, 32'd0,   1'b0};
    // Build credit to 2, then grant and dequeue together.
    vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 32'd0,   1'b0};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 3'd1, 1'b0, 32'd0,   1'b0};
    vecs[11] = '{4'b0100, 1'b1, 4'b0100, 3'd2, 1'b1, 32'd102, 1'b0};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 3'd2, 1'b0, 32'd0,   1'b0};
    // Pointer at 3: wrap from requester 3 to requester 0.
    vecs[13] = '{4'b1001, 1'b0, 4'b1000, 3'd2, 1'b1, 32'd103, 1'b0};
    vecs[14] = '{4'b1001, 1'b0, 4'b0001, 3'd1, 1'b1, 32'd100, 1'b0};
    // Refill to DEPTH, then overflow sets the sticky error.
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 32'd0,   1'b0};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 3'd1, 1'b0, 32'd0,   1'b0};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 3'd2, 1'b0, 32'd0,   1'b0};
    vecs[18] = '{4'b0000, 1'b1, 4'b0000, 3'd3, 1'b0, 32'd0,   1'b0};
    vecs[19] = '{4'b0000, 1'b1, 4'b0000, 3'd4, 1'b0, 32'd0,   1'b0};
    vecs[20] = '{4'b0000, 1'b1, 4'b0000, 3'd5, 1'b0, 32'd0,   1'b1};
    vecs[21] = '{4'b0000, 1'b0, 4'b0000, 3'd5, 1'b0, 32'd0,   1'b1};
    // Grant plus dequeue at full credit is legal: credit holds.
    vecs[22] = '{4'b0100, 1'b1, 4'b0100, 3'd5, 1'b1, 32'd102, 1'b1};

    bus.REQ      = 4'b1111;
    bus.DEQ_DONE = 1'b0;
`ifdef ARB_LOCK_EN
    bus.LOCK     = 1'b0;
`endif
    setDefaultData();
    rst = 1'b1;
    #3;
    checkOutput("rst_gnt",    64'(bus.GNT),    64'd0);
    checkOutput("rst_enq",    64'(bus.ENQ_O),  64'd0);
    checkOutput("rst_dout",   64'(bus.DOUT),   64'd0);
    checkOutput("rst_credit", 64'(bus.CREDIT), 64'd5);
    checkOutput("rst_err",    64'(bus.ERR),    64'd0);
    doReset();

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].req, vecs[i].deq, 1'b0);
      checkOutput($sformatf("v%0d_gnt", i),    64'(bus.GNT),    64'(vecs[i].gnt));
      checkOutput($sformatf("v%0d_credit", i), 64'(bus.CREDIT), 64'(vecs[i].credit));
      stepClock();
      checkOutput($sformatf("v%0d_enq", i),    64'(bus.ENQ_O),  64'(vecs[i].enq));
      checkOutput($sformatf("v%0d_dout", i),   64'(bus.DOUT),   64'(vecs[i].dout));
      checkOutput($sformatf("v%0d_err", i),    64'(bus.ERR),    64'(vecs[i].err));
    end

    // Reset mid-operation discards the pending enqueue and clears ERR.
    applyStimulus(4'b0001, 1'b0, 1'b0);
    stepClock();
    checkOutput("mid_enq_before", 64'(bus.ENQ_O), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_enq",    64'(bus.ENQ_O),  64'd0);
    checkOutput("mid_dout",   64'(bus.DOUT),   64'd0);
    checkOutput("mid_credit", 64'(bus.CREDIT), 64'd5);
    checkOutput("mid_err",    64'(bus.ERR),    64'd0);
    checkOutput("mid_gnt",    64'(bus.GNT),    64'd0);
    doReset();

    // Distinct per-requester data, pointer starting at 0.
    bus.DIN[1*WIDTH +: WIDTH] = 32'h0BAD_F00D;
    bus.DIN[3*WIDTH +: WIDTH] = 32'hA5A5_5A5A;
    applyStimulus(4'b1010, 1'b0, 1'b0);
    checkOutput("data_gnt1", 64'(bus.GNT), 64'b0010);
    stepClock();
    checkOutput("data_dout1", 64'(bus.DOUT), 64'h0BAD_F00D);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    checkOutput("data_gnt2", 64'(bus.GNT), 64'b1000);
    stepClock();
    checkOutput("data_dout2", 64'(bus.DOUT), 64'hA5A5_5A5A);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("data_credit", 64'(bus.CREDIT), 64'd3);
    stepClock();
    checkOutput("data_idle_dout", 64'(bus.DOUT), 64'd0);
    setDefaultData();

`ifdef ARB_LOCK_EN
    // Requester 2 takes the lock, holds it against full contention,
    // then releases it; the pointer moves past the owner.
    doReset();
    applyStimulus(4'b0100, 1'b0, 1'b1);
    checkOutput("lock_gnt0", 64'(bus.GNT), 64'b0100);
    stepClock();
    for (int i = 1; i < 3; i++) begin
      applyStimulus(4'b1111, 1'b0, 1'b1);
      checkOutput($sformatf("lock_gnt%0d", i), 64'(bus.GNT), 64'b0100);
      stepClock();
      checkOutput($sformatf("lock_dout%0d", i), 64'(bus.DOUT), 64'd102);
    end
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("lock_release_gnt", 64'(bus.GNT), 64'b0100);
    stepClock();
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("lock_after_gnt", 64'(bus.GNT), 64'b1000);
    checkOutput("lock_after_credit", 64'(bus.CREDIT), 64'd1);
    stepClock();
    checkOutput("lock_after_dout", 64'(bus.DOUT), 64'd103);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    stepClock();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
